control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control FSM for the 16-bit accumulator CPU; sits directly upstream of alu.
- Decodes the instruction register opcode and sequences PC, IR, memory, accumulator and flag writes.
- Drives the alu operation select and operand-B mux, and consumes the registered Z/N flags produced downstream of alu.
- Fixed 3 cycles per instruction (FETCH, DECODE, EXEC); HLT parks the FSM until reset.

Parameters:
- OPCODE_WIDTH, 5, width of instruction field [15:11].
- DATA_WIDTH, 16, datapath width; documentation and consistency only, no logic depends on it.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  synchronous, active-high reset.
- opcode_in  input  OPCODE_WIDTH  IR[15:11].
- flag_Z_in  input  1  registered zero flag.
- flag_N_in  input  1  registered negative flag.
- ir_load_out  output  1  load IR from memory data.
- pc_inc_out  output  1  PC <= PC+1.
- pc_load_out  output  1  PC <= IR[10:0].
- mem_addr_sel_out  output  1  0 = PC, 1 = IR[10:0].
- mem_write_out  output  1  memory[addr] <= ACC.
- alu_op_out  output  1  to alu_op_in: 0 = A+B, 1 = A-B.
- alu_B_sel_out  output  1  0 = memory data, 1 = sign-extended IR[10:0].
- acc_src_sel_out  output  1  0 = alu_out, 1 = operand-B mux.
- acc_load_out  output  1  ACC write enable.
- flags_load_out  output  1  Z/N register write enable, captured from alu_Z_out/alu_N_out.
- halted_out  output  1  high in HALT.

Behaviour:
- Clock and reset: single clock, clock_in; reset_in is synchronous and active-high.
- Memory model: read is combinational, write is synchronous.
- States: FETCH, DECODE, EXEC, HALT.
- Reset:
  - State goes to FETCH on the next edge.
  - All strobes (ir_load, pc_inc, pc_load, mem_write, acc_load, flags_load) and halted_out are forced to 0 while reset_in=1, including a reset asserted mid-instruction.
  - Select outputs are forced to 0 during reset.
- FETCH: mem_addr_sel=0, ir_load=1, pc_inc=1; next state DECODE.
- DECODE:
  - mem_addr_sel=1; no strobes.
  - Next state is HALT if opcode==HLT, else EXEC.
- EXEC: mem_addr_sel=1; strobes per opcode; next state FETCH.
- Opcode map (EXEC actions):
  - 00000 HLT: never reaches EXEC.
  - 00001 STO: mem_write=1.
  - 00010 LD: acc_src=1, B_sel=0, acc_load=1, flags_load=1.
  - 00011 LDI: as LD with B_sel=1.
  - 00100 ADD: alu_op=0, B_sel=0, acc_src=0, acc_load=1, flags_load=1.
  - 00101 ADDI: as ADD with B_sel=1.
  - 00110 SUB: alu_op=1, otherwise as ADD.
  - 00111 SUBI: alu_op=1, B_sel=1.
  - 01000 BEQ: pc_load = Z.
  - 01001 BNE: pc_load = !Z.
  - 01010 BLT: pc_load = N.
  - 01011 BGE: pc_load = !N.
  - 01100 JMP: pc_load=1.
  - 01101..11111: NOP, no strobes, FETCH continues.
- LD/LDI flag writes: flags come from the ALU with A=ACC; the datapath's flag mux is not used. Flags therefore reflect ACC+B on loads (documented quirk).
- Branch conditions sample flag_Z_in/flag_N_in in EXEC. Flags were written at the earliest by the previous instruction's EXEC, so they are always stable.
- Outputs are combinational from the state register and opcode_in.
- The state register is the only sequential element.
- Outside EXEC, alu_op_out and alu_B_sel_out hold 0.
- HALT:
  - halted_out=1, all strobes 0; stays in HALT until reset_in.
  - Opcode changes are ignored.
- pc_inc and pc_load are never high in the same cycle. Simultaneous requests are impossible by construction; assert this in the bench.
- Illegal state encoding goes to FETCH on the next edge, strobes 0.

Decomposition:
- Package cpu_pkg:
  - typedef enum state_t {FETCH, DECODE, EXEC, HALT}.
  - typedef enum opcode_t covering the 5-bit map above.
  - Constants ALU_ADD=1'b0, ALU_SUB=1'b1, B_MEM=0, B_IMM=1.
  - Shared with alu and the datapath.
- Sub-module control_decoder: combinational opcode+state+flags to strobe vector. The FSM wrapper holds the state register and reset gating.

Test Plan:
- Reset: hold reset_in 2 cycles from an arbitrary state, release -> cycle 0 FETCH with ir_load=1 and pc_inc=1; all strobes 0 during reset.
- ADDI (opcode 00101) -> DECODE cycle no strobes; EXEC shows alu_op=0, B_sel=1, acc_src=0, acc_load=1, flags_load=1; next cycle FETCH.
- SUB (00110) then STO (00001) -> EXEC alu_op=1, B_sel=0; the following EXEC shows mem_write=1 with acc_load=0; each instruction is exactly 3 cycles.
- BEQ with Z=1 -> pc_load=1; with Z=0 -> pc_load=0.
- BLT with N=1 -> pc_load=1; BGE with N=1 -> pc_load=0.
- JMP -> pc_load=1 regardless of flags.
- HLT (00000) -> halted_out=1 from the cycle after DECODE, held for 10+ cycles with opcode toggling; reset_in asserted mid-EXEC of ADD -> acc_load gated to 0 that cycle, FETCH follows.
- Opcode 11111 -> zero strobes in EXEC, FETCH next.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU: FSM states, opcode map,
// ALU/operand selects and the control strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Values 01101..11111 are unassigned and execute as NOP.
  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BLT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_JMP  = 5'b01100
  } opcode_t;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  localparam logic B_MEM   = 1'b0;
  localparam logic B_IMM   = 1'b1;

  typedef struct packed {
    logic ir_load;
    logic pc_inc;
    logic pc_load;
    logic mem_addr_sel;
    logic mem_write;
    logic alu_op;
    logic alu_b_sel;
    logic acc_src_sel;
    logic acc_load;
    logic flags_load;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of FSM state, opcode and flags into the control strobes.
module control_decoder
  import cpu_pkg::*;
(
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_n,
  output ctrl_t               ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    unique case (state)
      FETCH: begin
        ctrl_c.ir_load = 1'b1;
        ctrl_c.pc_inc  = 1'b1;
      end
      DECODE: ctrl_c.mem_addr_sel = 1'b1;
      EXEC: begin
        ctrl_c.mem_addr_sel = 1'b1;
        case (opcode)
          OP_STO: ctrl_c.mem_write = 1'b1;
          // Loads still write flags from the ALU (A=ACC), so Z/N reflect ACC+B.
          OP_LD, OP_LDI: begin
            ctrl_c.alu_b_sel   = (opcode == OP_LDI) ? B_IMM : B_MEM;
            ctrl_c.acc_src_sel = 1'b1;
            ctrl_c.acc_load    = 1'b1;
            ctrl_c.flags_load  = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            ctrl_c.alu_op     = (opcode == OP_SUB || opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            ctrl_c.alu_b_sel  = (opcode == OP_ADDI || opcode == OP_SUBI) ? B_IMM : B_MEM;
            ctrl_c.acc_load   = 1'b1;
            ctrl_c.flags_load = 1'b1;
          end
          OP_BEQ: ctrl_c.pc_load = flag_z;
          OP_BNE: ctrl_c.pc_load = ~flag_z;
          OP_BLT: ctrl_c.pc_load = flag_n;
          OP_BGE: ctrl_c.pc_load = ~flag_n;
          OP_JMP: ctrl_c.pc_load = 1'b1;
          default: ;
        endcase
      end
      HALT:    ctrl_c.halted = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC control FSM for the accumulator CPU; the state
// register is its only storage, all outputs decode combinationally from it.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic                    flag_Z_in,
  input  logic                    flag_N_in,
  output logic                    ir_load_out,
  output logic                    pc_inc_out,
  output logic                    pc_load_out,
  output logic                    mem_addr_sel_out,
  output logic                    mem_write_out,
  output logic                    alu_op_out,
  output logic                    alu_B_sel_out,
  output logic                    acc_src_sel_out,
  output logic                    acc_load_out,
  output logic                    flags_load_out,
  output logic                    halted_out
);

  // The opcode sits in IR[15:11]; any other geometry breaks the opcode map.
  if (OPCODE_WIDTH != OPCODE_W || DATA_WIDTH != 16) begin : g_bad_geometry
    $error("control_unit: unsupported OPCODE_WIDTH/DATA_WIDTH");
  end

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_c;
  ctrl_t  ctrl_gated_c;

  always_ff @(posedge clock_in) begin
    if (reset_in) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (opcode_in == OP_HLT) ? HALT : EXEC;
      EXEC:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  control_decoder u_decoder (
    .state  (state_q),
    .opcode (opcode_in),
    .flag_z (flag_Z_in),
    .flag_n (flag_N_in),
    .ctrl_c (ctrl_c)
  );

  // Reset kills every strobe immediately, even mid-instruction.
  assign ctrl_gated_c = reset_in ? '0 : ctrl_c;

  assign ir_load_out      = ctrl_gated_c.ir_load;
  assign pc_inc_out       = ctrl_gated_c.pc_inc;
  assign pc_load_out      = ctrl_gated_c.pc_load;
  assign mem_addr_sel_out = ctrl_gated_c.mem_addr_sel;
  assign mem_write_out    = ctrl_gated_c.mem_write;
  assign alu_op_out       = ctrl_gated_c.alu_op;
  assign alu_B_sel_out    = ctrl_gated_c.alu_b_sel;
  assign acc_src_sel_out  = ctrl_gated_c.acc_src_sel;
  assign acc_load_out     = ctrl_gated_c.acc_load;
  assign flags_load_out   = ctrl_gated_c.flags_load;
  assign halted_out       = ctrl_gated_c.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors against hand-written
// expectations, plus a running pc_inc/pc_load exclusivity check.
module tb_control_unit;
  import cpu_pkg::*;

  // Vector order: ir_load pc_inc pc_load addr_sel mem_write alu_op b_sel acc_src acc_load flags_load halted
  localparam logic [10:0] V_ZERO   = 11'b00000000000;
  localparam logic [10:0] V_FETCH  = 11'b11000000000;
  localparam logic [10:0] V_DECODE = 11'b00010000000;
  localparam logic [10:0] V_NOP    = 11'b00010000000;
  localparam logic [10:0] V_STO    = 11'b00011000000;
  localparam logic [10:0] V_LDI    = 11'b00010011110;
  localparam logic [10:0] V_ADD    = 11'b00010000110;
  localparam logic [10:0] V_ADDI   = 11'b00010010110;
  localparam logic [10:0] V_SUB    = 11'b00010100110;
  localparam logic [10:0] V_SUBI   = 11'b00010110110;
  localparam logic [10:0] V_BR_T   = 11'b00110000000;
  localparam logic [10:0] V_HALT   = 11'b00000000001;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic [4:0] opcode_in;
  logic       flag_Z_in;
  logic       flag_N_in;
  logic       ir_load_out, pc_inc_out, pc_load_out, mem_addr_sel_out, mem_write_out;
  logic       alu_op_out, alu_B_sel_out, acc_src_sel_out, acc_load_out, flags_load_out;
  logic       halted_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        mon_en   = 1'b0;

  always #5 clock_in = ~clock_in;

  control_unit #(.OPCODE_WIDTH(5), .DATA_WIDTH(16)) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .opcode_in        (opcode_in),
    .flag_Z_in        (flag_Z_in),
    .flag_N_in        (flag_N_in),
    .ir_load_out      (ir_load_out),
    .pc_inc_out       (pc_inc_out),
    .pc_load_out      (pc_load_out),
    .mem_addr_sel_out (mem_addr_sel_out),
    .mem_write_out    (mem_write_out),
    .alu_op_out       (alu_op_out),
    .alu_B_sel_out    (alu_B_sel_out),
    .acc_src_sel_out  (acc_src_sel_out),
    .acc_load_out     (acc_load_out),
    .flags_load_out   (flags_load_out),
    .halted_out       (halted_out)
  );

  wire [10:0] ctrl = {ir_load_out, pc_inc_out, pc_load_out, mem_addr_sel_out, mem_write_out,
                      alu_op_out, alu_B_sel_out, acc_src_sel_out, acc_load_out, flags_load_out,
                      halted_out};

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs[10:0], exp[10:0]);
    end
  endtask

  // Enter with the FSM in FETCH just after a falling edge; leaves it in FETCH again.
  task automatic run_instr(input string tag, input logic [4:0] op, input logic z, input logic n,
                           input logic [10:0] exec_exp);
    opcode_in = op;
    flag_Z_in = z;
    flag_N_in = n;
    #1;
    check_eq({tag, "_fetch"}, 16'(ctrl), 16'(V_FETCH));
    @(negedge clock_in);
    check_eq({tag, "_decode"}, 16'(ctrl), 16'(V_DECODE));
    @(negedge clock_in);
    check_eq({tag, "_exec"}, 16'(ctrl), 16'(exec_exp));
    @(negedge clock_in);
  endtask

  always @(negedge clock_in) begin
    if (mon_en) check_eq("pc_excl", 16'(pc_inc_out & pc_load_out), 16'h0000);
  end

  initial begin
    reset_in  = 1'b1;
    opcode_in = 5'b00100;
    flag_Z_in = 1'b0;
    flag_N_in = 1'b0;

    repeat (2) begin
      @(negedge clock_in);
      check_eq("reset_hold", 16'(ctrl), 16'(V_ZERO));
    end
    reset_in = 1'b0;
    mon_en   = 1'b1;

    run_instr("addi",     5'b00101, 1'b0, 1'b0, V_ADDI);
    run_instr("sub",      5'b00110, 1'b0, 1'b0, V_SUB);
    run_instr("sto",      5'b00001, 1'b0, 1'b0, V_STO);
    run_instr("ldi",      5'b00011, 1'b0, 1'b0, V_LDI);
    run_instr("subi",     5'b00111, 1'b1, 1'b1, V_SUBI);
    run_instr("beq_z1",   5'b01000, 1'b1, 1'b0, V_BR_T);
    run_instr("beq_z0",   5'b01000, 1'b0, 1'b1, V_NOP);
    run_instr("bne_z0",   5'b01001, 1'b0, 1'b0, V_BR_T);
    run_instr("blt_n1",   5'b01010, 1'b0, 1'b1, V_BR_T);
    run_instr("bge_n1",   5'b01011, 1'b1, 1'b1, V_NOP);
    run_instr("jmp_f00",  5'b01100, 1'b0, 1'b0, V_BR_T);
    run_instr("jmp_f11",  5'b01100, 1'b1, 1'b1, V_BR_T);
    run_instr("nop_1f",   5'b11111, 1'b1, 1'b0, V_NOP);
    run_instr("nop_0d",   5'b01101, 1'b0, 1'b1, V_NOP);

    // Reset arriving in the EXEC cycle of an ADD.
    opcode_in = 5'b00100;
    #1;
    check_eq("rst_add_fetch", 16'(ctrl), 16'(V_FETCH));
    @(negedge clock_in);
    check_eq("rst_add_decode", 16'(ctrl), 16'(V_DECODE));
    @(negedge clock_in);
    check_eq("rst_add_exec", 16'(ctrl), 16'(V_ADD));
    reset_in = 1'b1;
    #1;
    check_eq("rst_add_gated", 16'(ctrl), 16'(V_ZERO));
    @(negedge clock_in);
    check_eq("rst_add_hold", 16'(ctrl), 16'(V_ZERO));
    reset_in = 1'b0;
    run_instr("after_rst", 5'b00100, 1'b0, 1'b0, V_ADD);

    // HLT parks the FSM regardless of opcode/flag activity.
    opcode_in = 5'b00000;
    #1;
    check_eq("hlt_fetch", 16'(ctrl), 16'(V_FETCH));
    @(negedge clock_in);
    check_eq("hlt_decode", 16'(ctrl), 16'(V_DECODE));
    @(negedge clock_in);
    check_eq("hlt_enter", 16'(ctrl), 16'(V_HALT));
    for (int i = 0; i < 12; i++) begin
      opcode_in = 5'($urandom);
      flag_Z_in = 1'($urandom);
      flag_N_in = 1'($urandom);
      @(negedge clock_in);
      check_eq("hlt_park", 16'(ctrl), 16'(V_HALT));
    end

    reset_in = 1'b1;
    #1;
    check_eq("hlt_reset", 16'(ctrl), 16'(V_ZERO));
    @(negedge clock_in);
    reset_in = 1'b0;
    run_instr("post_hlt", 5'b00110, 1'b0, 1'b0, V_SUB);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
